// File: rtl/wash_phase_timer.sv
// Per-phase countdown for the washer controller: prescales CLOCK_50 to a 1 s tick,
// loads the duration of the phase the controller reports and pulses advance when it expires.
module wash_phase_timer #(
    parameter int TICK_DIV = 50000000,
    parameter int T_FILL   = 8,
    parameter int T_AGIT   = 10,
    parameter int T_SOAK   = 6,
    parameter int T_AGIT2  = 10,
    parameter int T_DRAIN  = 8,
    parameter int T_SPIN   = 12,
    parameter int CNT_W    = 8
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic [2:0]       phase,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    output logic             advance,
    output logic [CNT_W-1:0] time_left,
    output logic             running,
    output logic             done,
    output logic             tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        PAUSED,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] time_left_q, time_left_d;
    logic             advance_q, advance_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic             tick_q, tick_d;
    logic             start_q;
    logic             start_edge;
    logic             presc_wrap;
    logic [CNT_W-1:0] phase_dur;

    function automatic logic [CNT_W-1:0] duration_of(input logic [2:0] p);
        case (p)
            3'd1:    duration_of = CNT_W'(T_FILL);
            3'd2:    duration_of = CNT_W'(T_AGIT);
            3'd3:    duration_of = CNT_W'(T_SOAK);
            3'd4:    duration_of = CNT_W'(T_AGIT2);
            3'd5:    duration_of = CNT_W'(T_DRAIN);
            3'd6:    duration_of = CNT_W'(T_SPIN);
            default: duration_of = '0;
        endcase
    endfunction

    assign start_edge = start && !start_q;
    assign presc_wrap = (presc_q == PRESC_LAST);
    assign phase_dur  = duration_of(phase);

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        time_left_d = time_left_q;
        advance_d   = 1'b0;
        tick_d      = 1'b0;

        if (abort) begin
            state_d     = IDLE;
            presc_d     = '0;
            time_left_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    presc_d     = '0;
                    time_left_d = '0;
                    if (start_edge && phase == 3'd0) begin
                        advance_d = 1'b1;
                        state_d   = LOAD;
                    end
                end
                LOAD: begin
                    presc_d = '0;
                    // While our own advance is still visible the controller has not stepped yet.
                    if (!advance_q) begin
                        if (phase == 3'd0) begin
                            state_d     = DONE;
                            time_left_d = '0;
                        end else if (phase == 3'd7) begin
                            state_d     = IDLE;
                            time_left_d = '0;
                        end else if (phase_dur == '0) begin
                            advance_d   = 1'b1;
                            time_left_d = '0;
                        end else begin
                            time_left_d = phase_dur;
                            state_d     = RUN;
                        end
                    end
                end
                RUN: begin
                    if (presc_wrap) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        if (time_left_q > CNT_W'(1)) begin
                            time_left_d = time_left_q - CNT_W'(1);
                        end else begin
                            time_left_d = '0;
                            advance_d   = 1'b1;
                            state_d     = LOAD;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                    if (pause && state_d == RUN) begin
                        state_d = PAUSED;
                    end
                end
                PAUSED: begin
                    if (!pause) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    presc_d     = '0;
                    time_left_d = '0;
                    if (!start) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    presc_d     = '0;
                    time_left_d = '0;
                end
            endcase
        end

        running_d = (state_d == RUN) || (state_d == PAUSED);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            time_left_q <= '0;
            advance_q   <= 1'b0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            tick_q      <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            time_left_q <= time_left_d;
            advance_q   <= advance_d;
            running_q   <= running_d;
            done_q      <= done_d;
            tick_q      <= tick_d;
            start_q     <= start;
        end
    end

    assign advance   = advance_q;
    assign time_left = time_left_q;
    assign running   = running_q;
    assign done      = done_q;
    assign tick      = tick_q;

endmodule

// File: doc/wash_phase_timer.md
Name: wash_phase_timer

Overview:
- Upstream timing stage for the washer controller FSM.
- Watches the controller's current phase code (0 espera, 1 encher, 2 agitar, 3 tempo, 4 agitar2, 5 esvaziar, 6 centrifugar).
- Counts a per-phase duration in seconds and emits a one-cycle advance pulse that drives the controller's step input.
- Also provides pause/abort control and a seconds-remaining value for LED/7-seg display.

Parameters:
- TICK_DIV, 50000000, CLOCK_50 cycles per 1 s tick (set small in simulation).
- T_FILL, 8, seconds in phase 1.
- T_AGIT, 10, seconds in phase 2.
- T_SOAK, 6, seconds in phase 3.
- T_AGIT2, 10, seconds in phase 4.
- T_DRAIN, 8, seconds in phase 5.
- T_SPIN, 12, seconds in phase 6.
- CNT_W, 8, width of the seconds counter; all T_* must be < 2^CNT_W.

Ports:
- CLOCK_50  in  1  system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- phase  in  3  current phase code from the washer controller.
- start  in  1  level; a rising edge while IDLE begins a wash cycle.
- pause  in  1  level; while 1, the countdown freezes.
- abort  in  1  level; synchronous return to IDLE.
- advance  out  1  one-cycle pulse telling the controller to step to the next phase.
- time_left  out  CNT_W  seconds remaining in the current phase.
- running  out  1  1 in RUN and PAUSED.
- done  out  1  1 in DONE.
- tick  out  1  one-cycle 1 s strobe (debug).

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - state=IDLE; prescaler=0; time_left=0.
  - advance=0, running=0, done=0, tick=0.
  - start edge register=0.
- All outputs are registered.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN; tick=1 on the cycle it wraps.
  - Held (not cleared) in PAUSED; cleared to 0 in every other state and on each LOAD.
- States: IDLE, LOAD, RUN, PAUSED, DONE.
- IDLE:
  - On a start rising edge (start=1, previous start=0) with phase==0: pulse advance for 1 cycle, then go to LOAD.
  - A start edge with phase!=0 is ignored.
- LOAD (1 cycle; the controller's phase updates one cycle after advance):
  - phase in 1..6: time_left=T[phase], then go to RUN.
  - If T[phase]==0: pulse advance immediately and stay in LOAD (phase skip).
  - phase==0: the cycle has wrapped; go to DONE.
  - phase==7: go to IDLE; time_left=0.
- RUN:
  - On tick with time_left>1: decrement time_left.
  - On tick with time_left==1: time_left=0, pulse advance, go to LOAD.
  - pause=1 moves to PAUSED on the next cycle.
  - If tick and pause=1 occur in the same cycle, the tick is processed first (decrement or advance), then pause is honoured.
- PAUSED:
  - time_left and prescaler are frozen; no ticks.
  - pause=0 returns to RUN, resuming the prescaler from its held value.
- DONE:
  - done=1, time_left=0.
  - Stays until start==0, then goes to IDLE.
  - A new cycle requires a fresh start rising edge.
- abort=1:
  - Highest priority below reset; from any state go to IDLE next cycle.
  - time_left=0, prescaler=0, advance=0 in that cycle.
  - An advance pulse is never issued in the same cycle as abort.
- advance is never high for 2 consecutive cycles; at most one pulse per phase.
- Decrement never wraps below 0.
- The counter width is fixed at CNT_W; durations are zero-extended to CNT_W.

Test Plan (TICK_DIV=4, T_FILL=2, T_AGIT=3, T_SOAK=1, T_AGIT2=3, T_DRAIN=2, T_SPIN=2; bench models the controller: phase increments mod 7 the cycle after advance):
- Reset mid-RUN (RESET_N low during phase 2, time_left=2) -> all outputs 0 immediately, state IDLE; after release, no advance until a new start edge.
- Full cycle: start edge at phase 0 -> advance at t0.
  - time_left loads 2, 3, 1, 3, 2, 2 in turn.
  - Each phase lasts T*4 cycles + 2 overhead.
  - 7 advance pulses total; DONE with done=1 after phase 6; start low -> IDLE.
- Pause: assert pause in phase 2 at time_left=2 for 20 cycles -> time_left stays 2, running=1, no tick; release -> decrement to 1 exactly 4 cycles after the prescaler resumes (held count honoured).
- Abort in phase 4 at time_left=3 -> next cycle IDLE, time_left=0, advance=0; start held high gives no restart until it drops and rises again.
- Tick+pause same cycle at time_left=1 -> advance pulses once, LOAD/RUN of next phase, then PAUSED with time_left=T of the new phase.
- Zero-duration phase (T_SOAK=0) -> back-to-back skip: advance pulses in LOAD for phase 3, never in consecutive cycles; phase 4 loads 3.
